wasm_stack_ctrl: RTL and testbench

- Sequencer in front of the WASM operand stack.
- Accepts one decoded instruction's stack effect at a time: pop count 0..3, push 0/1, and either an ALU result or a bypass immediate.
- Keeps the stack frozen while the ALU reads the top-of-stack window, then issues exactly one combined pop/push command to the stack. Tracks shadow depth.
- Traps on underflow/overflow before any stack command is issued.

---
 rtl/wasm_stack_ctrl.sv | 154 +++++++++++++++
 tb/tb_wasm_stack_ctrl.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/wasm_stack_ctrl.sv
// Operand-stack sequencer: checks a decoded instruction's stack effect, runs the ALU, then issues one pop/push command.
// Optional ALU watchdog is enabled by defining WASM_STACK_CTRL_TIMEOUT_EN.
module wasm_stack_ctrl #(
    parameter int ST_DEPTH    = 16,
    parameter int ST_WIDTH    = 32,
    parameter int DEPTH_W     = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                instr_valid,
    output logic                instr_ready,
    input  logic [1:0]          instr_pop,
    input  logic                instr_push,
    input  logic                instr_bypass,
    input  logic [ST_WIDTH-1:0] instr_imm,
    output logic                alu_start,
    input  logic                alu_done,
    input  logic [ST_WIDTH-1:0] alu_result,
    output logic                st_push_num,
    output logic [3:0]          st_pop_num,
    output logic [ST_WIDTH-1:0] st_push_data,
    output logic                retire,
    output logic [DEPTH_W-1:0]  depth,
    output logic                busy,
    output logic                trap,
    output logic [1:0]          trap_code,
    input  logic                trap_clr
);

    typedef enum logic [2:0] {IDLE, EXEC, WAIT, COMMIT, TRAP} state_t;

    state_t             state, state_nxt;
    logic [1:0]         pop_q;
    logic               push_q;
    logic               accept;
    logic               underflow;
    logic               overflow;
    logic [DEPTH_W:0]   depth_ext;
    logic [DEPTH_W:0]   depth_after;

    // One extra bit so depth - pop + push cannot wrap when the stack is nearly full.
    assign depth_ext   = {1'b0, depth};
    assign depth_after = depth_ext - (DEPTH_W+1)'(instr_pop) + (DEPTH_W+1)'(instr_push);
    assign underflow   = (DEPTH_W+1)'(instr_pop) > depth_ext;
    assign overflow    = depth_after > (DEPTH_W+1)'(ST_DEPTH - 1);
    assign accept      = instr_valid && (state == IDLE);

`ifdef WASM_STACK_CTRL_TIMEOUT_EN
    logic [7:0] wait_cnt;
    logic       timeout;

    assign timeout = (wait_cnt == 8'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == EXEC) begin
            wait_cnt <= '0;
        end else if (state == WAIT && !alu_done) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end
`else
    logic timeout;

    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (underflow || overflow) begin
                        state_nxt = TRAP;
                    end else if (instr_bypass) begin
                        state_nxt = COMMIT;
                    end else begin
                        state_nxt = EXEC;
                    end
                end
            end
            EXEC:   state_nxt = WAIT;
            WAIT: begin
                if (alu_done) begin
                    state_nxt = COMMIT;
                end else if (timeout) begin
                    state_nxt = TRAP;
                end
            end
            COMMIT: state_nxt = IDLE;
            TRAP: begin
                if (trap_clr) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latched descriptor, push data, shadow depth and trap cause.
    always_ff @(posedge clk) begin
        if (rst) begin
            depth        <= '0;
            trap_code    <= 2'b00;
            st_push_data <= '0;
            pop_q        <= 2'b00;
            push_q       <= 1'b0;
        end else begin
            if (accept) begin
                pop_q  <= instr_pop;
                push_q <= instr_push;
                if (underflow) begin
                    trap_code <= 2'b01;
                end else if (overflow) begin
                    trap_code <= 2'b10;
                end else if (instr_bypass) begin
                    st_push_data <= instr_imm;
                end
            end
            if (state == WAIT && alu_done) begin
                st_push_data <= alu_result;
            end
            if (state == WAIT && !alu_done && timeout) begin
                trap_code <= 2'b11;
            end
            if (state == COMMIT) begin
                depth <= depth - DEPTH_W'(pop_q) + DEPTH_W'(push_q);
            end
            if (state == TRAP && trap_clr) begin
                trap_code <= 2'b00;
            end
        end
    end

    // Stack command is asserted only in COMMIT so the stack holds its window until then.
    assign instr_ready = (state == IDLE);
    assign alu_start   = (state == EXEC);
    assign retire      = (state == COMMIT);
    assign st_pop_num  = (state == COMMIT) ? {2'b00, pop_q} : 4'b0000;
    assign st_push_num = (state == COMMIT) ? push_q : 1'b0;
    assign busy        = (state != IDLE);
    assign trap        = (state == TRAP);

endmodule

// File: tb/tb_wasm_stack_ctrl.sv
// Scoreboard bench for wasm_stack_ctrl: expected stack commands are queued at issue and matched on retire.
module tb_wasm_stack_ctrl;

    localparam int ST_DEPTH = 16;
    localparam int ST_WIDTH = 32;
    localparam int DEPTH_W  = 4;

    logic                clk;
    logic                rst;
    logic                instr_valid;
    logic                instr_ready;
    logic [1:0]          instr_pop;
    logic                instr_push;
    logic                instr_bypass;
    logic [ST_WIDTH-1:0] instr_imm;
    logic                alu_start;
    logic                alu_done;
    logic [ST_WIDTH-1:0] alu_result;
    logic                st_push_num;
    logic [3:0]          st_pop_num;
    logic [ST_WIDTH-1:0] st_push_data;
    logic                retire;
    logic [DEPTH_W-1:0]  depth;
    logic                busy;
    logic                trap;
    logic [1:0]          trap_code;
    logic                trap_clr;

    wasm_stack_ctrl #(
        .ST_DEPTH(ST_DEPTH), .ST_WIDTH(ST_WIDTH), .DEPTH_W(DEPTH_W), .TIMEOUT_CYC(255)
    ) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_pop(instr_pop), .instr_push(instr_push),
        .instr_bypass(instr_bypass), .instr_imm(instr_imm),
        .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
        .st_push_num(st_push_num), .st_pop_num(st_pop_num), .st_push_data(st_push_data),
        .retire(retire), .depth(depth), .busy(busy),
        .trap(trap), .trap_code(trap_code), .trap_clr(trap_clr)
    );

    typedef struct {
        logic [3:0]          pop;
        logic                push;
        logic [ST_WIDTH-1:0] data;
    } cmd_t;

    cmd_t sb_q[$];
    cmd_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   n_start = 0;
    int   mdepth = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (alu_start) n_start++;
            if (retire) begin
                if (sb_q.size() == 0) begin
                    chk("retire_unexpected", 1, 0);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("st_pop_num", st_pop_num, mon_e.pop);
                    chk("st_push_num", st_push_num, mon_e.push);
                    chk("st_push_data", st_push_data, mon_e.data);
                end
            end
        end
    end

    // alu_lat < 0: accept an ALU instruction and leave it in flight.
    task automatic exec_instr(input int pop, input int push, input int byp,
                              input logic [31:0] imm, input int alu_lat, input logic [31:0] res);
        int   wn;
        int   start0;
        logic exp_trap;
        logic [1:0] exp_code;
        cmd_t e;
        exp_trap = 1'b1;
        exp_code = 2'b00;
        if (pop > mdepth) exp_code = 2'b01;
        else if (mdepth - pop + push > ST_DEPTH - 1) exp_code = 2'b10;
        else exp_trap = 1'b0;

        wn = 0;
        while (!instr_ready && wn < 20) begin
            @(negedge clk);
            wn++;
        end
        if (!instr_ready) chk("ready_timeout", 0, 1);
        start0 = n_start;
        instr_pop    = 2'(pop);
        instr_push   = 1'(push);
        instr_bypass = 1'(byp);
        instr_imm    = imm;
        instr_valid  = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;

        if (exp_trap) begin
            chk("trap_set", trap, 1);
            chk("trap_code", trap_code, exp_code);
            chk("trap_ready", instr_ready, 0);
            chk("trap_retire", retire, 0);
            @(negedge clk);
            chk("trap_depth", depth, mdepth);
            chk("trap_no_start", n_start - start0, 0);
            trap_clr = 1'b1;
            @(negedge clk);
            trap_clr = 1'b0;
            chk("clr_trap", trap, 0);
            chk("clr_code", trap_code, 0);
            chk("clr_ready", instr_ready, 1);
            return;
        end

        if (alu_lat < 0) begin
            chk("inflight_start", alu_start, 1);
            return;
        end

        e.pop  = 4'(pop);
        e.push = 1'(push);
        e.data = byp ? imm : res;
        sb_q.push_back(e);
        mdepth = mdepth - pop + push;

        if (byp) begin
            chk("byp_retire_lat", retire, 1);
            @(negedge clk);
            chk("byp_ready_lat", instr_ready, 1);
        end else begin
            chk("alu_start", alu_start, 1);
            repeat (alu_lat) @(negedge clk);
            alu_done   = 1'b1;
            alu_result = res;
            @(negedge clk);
            alu_done = 1'b0;
            chk("alu_retire_lat", retire, 1);
            @(negedge clk);
            chk("alu_start_count", n_start - start0, 1);
            chk("alu_ready", instr_ready, 1);
        end
        chk("depth", depth, mdepth);
        chk("sb_drained", sb_q.size(), 0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_depth"}, depth, 0);
        chk({tag, "_trap"}, trap, 0);
        chk({tag, "_code"}, trap_code, 0);
        chk({tag, "_retire"}, retire, 0);
        chk({tag, "_alu_start"}, alu_start, 0);
        chk({tag, "_push_num"}, st_push_num, 0);
        chk({tag, "_pop_num"}, st_pop_num, 0);
        chk({tag, "_push_data"}, st_push_data, 0);
        chk({tag, "_ready"}, instr_ready, 1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        instr_valid = 1'b0;
        instr_pop = 2'b00;
        instr_push = 1'b0;
        instr_bypass = 1'b0;
        instr_imm = '0;
        alu_done = 1'b0;
        alu_result = '0;
        trap_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_reset_state("reset");

        exec_instr(0, 1, 1, 32'h0000002A, 0, 0);
        exec_instr(0, 1, 1, 32'h00000005, 0, 0);
        exec_instr(2, 1, 0, 0, 3, 32'h00000007);
        exec_instr(2, 1, 0, 0, 3, 32'h00000009);
        exec_instr(0, 0, 1, 32'h00000099, 0, 0);
        for (int i = 0; i < 14; i++) exec_instr(0, 1, 1, 32'(32'h100 + i), 0, 0);
        chk("fill_depth", depth, 15);
        exec_instr(0, 1, 1, 32'hDEAD, 0, 0);
        exec_instr(1, 1, 0, 0, 2, 32'h0000ABCD);
        exec_instr(3, 0, 0, 0, 1, 32'h00000001);

        exec_instr(1, 1, 0, 0, -1, 0);
`ifdef WASM_STACK_CTRL_TIMEOUT_EN
        n = 0;
        while (!trap && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("timeout_cycles", n, 256);
        chk("timeout_code", trap_code, 2'b11);
        chk("timeout_depth", depth, mdepth);
        trap_clr = 1'b1;
        @(negedge clk);
        trap_clr = 1'b0;
        chk("timeout_clr", trap, 0);
        exec_instr(1, 1, 0, 0, -1, 0);
        repeat (3) @(negedge clk);
`else
        n = 0;
        repeat (300) begin
            @(negedge clk);
            if (trap) n++;
        end
        chk("no_timeout_trap", n, 0);
        chk("no_timeout_code", trap_code, 0);
`endif
        chk("wait_busy", busy, 1);
        chk("wait_depth", depth, mdepth);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdepth = 0;
        chk_reset_state("mid_reset");
        @(negedge clk);
        chk("post_reset_retire", retire, 0);
        chk("post_reset_sb", sb_q.size(), 0);
        exec_instr(0, 1, 1, 32'h00000077, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
